// File: rtl/hlc_event_queue_if.sv
// Input/event bus of the RTLola monitor front-end: producer-side samples in,
// LLC-side timestamped events and queue status out.
interface hlc_event_queue_if #(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAGE_W = 64,
  parameter int unsigned TIME_W  = 64
);
  localparam int unsigned LANE_W = NUM_IN * DATA_W;
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

  logic                en;
  logic [LANE_W-1:0]   in_data;
  logic [NUM_IN-1:0]   in_new;

  logic                evt_valid;
  logic [LANE_W-1:0]   evt_data;
  logic [NUM_IN-1:0]   evt_new;
  logic                evt_periodic;
  logic [TIME_W-1:0]   evt_time;
  logic [STAGE_W-1:0]  llc_stage;
  logic [FILL_W-1:0]   fill_level;
  logic                overflow;
  logic [15:0]         drop_cnt;

  modport master (
    output en, in_data, in_new,
    input  evt_valid, evt_data, evt_new, evt_periodic, evt_time,
           llc_stage, fill_level, overflow, drop_cnt
  );

  modport slave (
    input  en, in_data, in_new,
    output evt_valid, evt_data, evt_new, evt_periodic, evt_time,
           llc_stage, fill_level, overflow, drop_cnt
  );
endinterface

// File: rtl/hlc_event_queue.sv
// Monitor input front-end: samples input streams plus a periodic tick into
// timestamped events, queues them and releases one per LLC round at stage 0.
module hlc_event_queue #(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAGES  = 5,
  parameter int unsigned STAGE_W = 64,
  parameter int unsigned TIME_W  = 64,
  parameter int unsigned PERIOD  = 500
) (
  input logic               clk,
  input logic               rst,
  hlc_event_queue_if.slave  bus
);
  localparam int unsigned LANE_W = NUM_IN * DATA_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned PER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
  localparam logic [PER_W-1:0]   LAST_COUNT = PER_W'(PERIOD - 1);
  localparam logic [FILL_W-1:0]  FULL_COUNT = FILL_W'(DEPTH);

  // Free-running counters
  logic [TIME_W-1:0]  time_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic [STAGE_W-1:0] stage_q;

  // Queue storage and bookkeeping
  logic [TIME_W-1:0]  mem_time [DEPTH];
  logic [NUM_IN-1:0]  mem_new  [DEPTH];
  logic [LANE_W-1:0]  mem_data [DEPTH];
  logic               mem_tick [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FILL_W-1:0]  count;

  // Registered event outputs
  logic               evt_valid_q;
  logic [LANE_W-1:0]  evt_data_q;
  logic [NUM_IN-1:0]  evt_new_q;
  logic               evt_periodic_q;
  logic [TIME_W-1:0]  evt_time_q;
  logic               overflow_q;
  logic [15:0]        drop_cnt_q;

  logic               tick_c;
  logic               last_stage_c;
  logic               push_req_c;
  logic               pop_c;
  logic               full_c;
  logic               wr_en_c;
  logic               drop_c;
  logic [LANE_W-1:0]  masked_c;

  // Lanes without a new flag are stored as zero
  always_comb begin
    masked_c = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.in_new[i]) begin
        masked_c[i*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A full queue still accepts a push when the same edge pops the head
  always_comb begin
    tick_c       = (PERIOD != 0) && (per_cnt == LAST_COUNT);
    last_stage_c = (stage_q == LAST_STAGE);
    push_req_c   = bus.en && ((|bus.in_new) || tick_c);
    pop_c        = bus.en && last_stage_c && (count != '0);
    full_c       = (count == FULL_COUNT);
    wr_en_c      = push_req_c && (!full_c || pop_c);
    drop_c       = push_req_c && full_c && !pop_c;
  end

  // Storage has no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_time[wr_ptr] <= time_cnt;
      mem_new[wr_ptr]  <= bus.in_new;
      mem_data[wr_ptr] <= masked_c;
      mem_tick[wr_ptr] <= tick_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_cnt       <= '0;
      per_cnt        <= '0;
      stage_q        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      evt_valid_q    <= 1'b0;
      evt_data_q     <= '0;
      evt_new_q      <= '0;
      evt_periodic_q <= 1'b0;
      evt_time_q     <= '0;
      overflow_q     <= 1'b0;
      drop_cnt_q     <= '0;
    end else if (bus.en) begin
      time_cnt <= time_cnt + TIME_W'(1);
      stage_q  <= last_stage_c ? '0 : stage_q + STAGE_W'(1);
      per_cnt  <= ((PERIOD == 0) || tick_c) ? '0 : per_cnt + PER_W'(1);

      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + FILL_W'(wr_en_c) - FILL_W'(pop_c);

      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      // Payload is loaded only on a pop and otherwise held for the LLC
      evt_valid_q <= pop_c;
      if (pop_c) begin
        evt_data_q     <= mem_data[rd_ptr];
        evt_new_q      <= mem_new[rd_ptr];
        evt_periodic_q <= mem_tick[rd_ptr];
        evt_time_q     <= mem_time[rd_ptr];
      end
    end
  end

  assign bus.evt_valid    = evt_valid_q;
  assign bus.evt_data     = evt_data_q;
  assign bus.evt_new      = evt_new_q;
  assign bus.evt_periodic = evt_periodic_q;
  assign bus.evt_time     = evt_time_q;
  assign bus.llc_stage    = stage_q;
  assign bus.fill_level   = count;
  assign bus.overflow     = overflow_q;
  assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_hlc_event_queue.sv
// Directed bench for hlc_event_queue: vector table for the basic event path,
// hand sequences for overflow, enable freeze, async reset and periodic ticks.
module tb_hlc_event_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hlc_event_queue_if #(.NUM_IN(3), .DATA_W(64), .DEPTH(8), .STAGE_W(64), .TIME_W(64)) bus_m ();
  hlc_event_queue_if #(.NUM_IN(3), .DATA_W(64), .DEPTH(8), .STAGE_W(64), .TIME_W(64)) bus_p ();

  hlc_event_queue #(.NUM_IN(3), .DATA_W(64), .DEPTH(8), .STAGES(5), .STAGE_W(64),
                    .TIME_W(64), .PERIOD(0))
    dut_m (.clk(clk), .rst(rst), .bus(bus_m));

  hlc_event_queue #(.NUM_IN(3), .DATA_W(64), .DEPTH(8), .STAGES(5), .STAGE_W(64),
                    .TIME_W(64), .PERIOD(10))
    dut_p (.clk(clk), .rst(rst), .bus(bus_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  in_new;
    logic [63:0] d0, d1, d2;
    logic        exp_valid;
    logic [2:0]  exp_new;
    logic [63:0] e0, e1, e2;
    logic [63:0] exp_time;
    logic [63:0] exp_stage;
    logic [3:0]  exp_fill;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int n, input logic [2:0] nw, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [63:0] a2, input logic [3:0] fl);
    vecs[n].in_new   = nw;
    vecs[n].d0       = a0;
    vecs[n].d1       = a1;
    vecs[n].d2       = a2;
    vecs[n].exp_fill = fl;
  endtask

  task automatic set_pop(input int n, input logic [2:0] nw, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] t);
    vecs[n].exp_valid = 1'b1;
    vecs[n].exp_new   = nw;
    vecs[n].e0        = a0;
    vecs[n].e1        = a1;
    vecs[n].e2        = a2;
    vecs[n].exp_time  = t;
  endtask

  initial begin
    logic [2:0]  h_new;
    logic [63:0] h0, h1, h2, h_time;
    logic [63:0] exp_t;
    logic [63:0] p_time [3];
    logic [2:0]  p_new  [3];
    logic [63:0] p_d0   [3];
    int          peak, pops;

    checks = 0;
    errors = 0;

    // Stage after edge n is (n+1)%5; fill/pushes/pops overridden below
    for (int n = 0; n < 30; n++) begin
      vecs[n] = '{in_new: 3'b000, d0: 64'd0, d1: 64'd0, d2: 64'd0, exp_valid: 1'b0,
                  exp_new: 3'b000, e0: 64'd0, e1: 64'd0, e2: 64'd0, exp_time: 64'd0,
                  exp_stage: 64'((n + 1) % 5), exp_fill: 4'd0};
    end
    set_vec(5, 3'b111, 64'd1, 64'd1, 64'd2, 4'd1);
    for (int n = 6; n <= 8; n++) vecs[n].exp_fill = 4'd1;
    set_pop(9, 3'b111, 64'd1, 64'd1, 64'd2, 64'd5);
    set_vec(12, 3'b101, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 4'd1);
    vecs[13].exp_fill = 4'd1;
    set_pop(14, 3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd12);
    set_vec(18, 3'b010, 64'd77, 64'd9, 64'd88, 4'd1);
    set_pop(19, 3'b010, 64'd0, 64'd9, 64'd0, 64'd18);
    set_vec(21, 3'b001, 64'd4, 64'd55, 64'd0, 4'd1);
    vecs[22].exp_fill = 4'd1;
    vecs[23].exp_fill = 4'd1;
    set_vec(24, 3'b100, 64'd0, 64'd0, 64'd6, 4'd1);
    set_pop(24, 3'b001, 64'd4, 64'd0, 64'd0, 64'd21);
    for (int n = 25; n <= 28; n++) vecs[n].exp_fill = 4'd1;
    set_pop(29, 3'b100, 64'd0, 64'd0, 64'd6, 64'd24);

    p_time = '{64'd9, 64'd19, 64'd29};
    p_new  = '{3'b000, 3'b001, 3'b000};
    p_d0   = '{64'd0, 64'd42, 64'd0};

    rst = 1'b1;
    bus_m.en = 1'b0; bus_m.in_new = '0; bus_m.in_data = '0;
    bus_p.en = 1'b0; bus_p.in_new = '0; bus_p.in_data = '0;
    repeat (3) step();

    chk("rst_valid",    64'(bus_m.evt_valid), 64'd0);
    chk("rst_stage",    bus_m.llc_stage, 64'd0);
    chk("rst_fill",     64'(bus_m.fill_level), 64'd0);
    chk("rst_time",     bus_m.evt_time, 64'd0);
    chk("rst_data",     64'(|bus_m.evt_data), 64'd0);
    chk("rst_overflow", 64'(bus_m.overflow), 64'd0);
    chk("rst_drop",     64'(bus_m.drop_cnt), 64'd0);
    chk("rst_p_stage",  bus_p.llc_stage, 64'd0);

    rst = 1'b0;
    bus_m.en = 1'b1;

    // Table: inputs applied before edge n, outputs checked just after it
    h_new = '0; h0 = '0; h1 = '0; h2 = '0; h_time = '0;
    for (int n = 0; n < 30; n++) begin
      bus_m.in_new  = vecs[n].in_new;
      bus_m.in_data = {vecs[n].d2, vecs[n].d1, vecs[n].d0};
      step();
      if (vecs[n].exp_valid) begin
        h_new = vecs[n].exp_new; h0 = vecs[n].e0; h1 = vecs[n].e1; h2 = vecs[n].e2;
        h_time = vecs[n].exp_time;
      end
      chk($sformatf("v%0d_valid", n), 64'(bus_m.evt_valid), 64'(vecs[n].exp_valid));
      chk($sformatf("v%0d_new", n),   64'(bus_m.evt_new), 64'(h_new));
      chk($sformatf("v%0d_lane0", n), bus_m.evt_data[63:0], h0);
      chk($sformatf("v%0d_lane1", n), bus_m.evt_data[127:64], h1);
      chk($sformatf("v%0d_lane2", n), bus_m.evt_data[191:128], h2);
      chk($sformatf("v%0d_time", n),  bus_m.evt_time, h_time);
      chk($sformatf("v%0d_periodic", n), 64'(bus_m.evt_periodic), 64'd0);
      chk($sformatf("v%0d_stage", n), bus_m.llc_stage, vecs[n].exp_stage);
      chk($sformatf("v%0d_fill", n),  64'(bus_m.fill_level), 64'(vecs[n].exp_fill));
      chk($sformatf("v%0d_ovf", n),   64'(bus_m.overflow), 64'd0);
    end

    // Overflow: 12 back-to-back pushes (edges 30..41), pops at 34 and 39
    peak = 0; pops = 0; exp_t = 64'd30;
    for (int n = 30; n < 80; n++) begin
      bus_m.in_new  = (n <= 41) ? 3'b001 : 3'b000;
      bus_m.in_data = {64'd0, 64'd0, 64'(n)};
      step();
      if (int'(bus_m.fill_level) > peak) peak = int'(bus_m.fill_level);
      if (bus_m.evt_valid) begin
        chk($sformatf("ovf_pop%0d_time", pops),  bus_m.evt_time, exp_t);
        chk($sformatf("ovf_pop%0d_lane0", pops), bus_m.evt_data[63:0], exp_t);
        chk($sformatf("ovf_pop%0d_new", pops),   64'(bus_m.evt_new), 64'd1);
        exp_t = exp_t + 64'd1;
        pops++;
      end
    end
    chk("ovf_peak_fill", 64'(peak), 64'd8);
    chk("ovf_overflow",  64'(bus_m.overflow), 64'd1);
    chk("ovf_drop_cnt",  64'(bus_m.drop_cnt), 64'd2);
    chk("ovf_pops",      64'(pops), 64'd10);
    chk("ovf_fill_end",  64'(bus_m.fill_level), 64'd0);

    // Queue three entries, then freeze with inputs asserted
    for (int n = 80; n < 83; n++) begin
      bus_m.in_new  = 3'b010;
      bus_m.in_data = {64'd0, 64'(n), 64'd0};
      step();
    end
    chk("q3_fill",  64'(bus_m.fill_level), 64'd3);
    chk("q3_stage", bus_m.llc_stage, 64'd3);
    bus_m.en = 1'b0;
    bus_m.in_new = 3'b111;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("frz%0d_stage", k), bus_m.llc_stage, 64'd3);
      chk($sformatf("frz%0d_fill", k),  64'(bus_m.fill_level), 64'd3);
      chk($sformatf("frz%0d_time", k),  bus_m.evt_time, 64'd39);
      chk($sformatf("frz%0d_valid", k), 64'(bus_m.evt_valid), 64'd0);
    end
    bus_m.in_new = 3'b000;
    bus_m.en = 1'b1;
    step();
    chk("thaw_stage", bus_m.llc_stage, 64'd4);
    step();
    chk("thaw_valid", 64'(bus_m.evt_valid), 64'd1);
    chk("thaw_time",  bus_m.evt_time, 64'd80);
    chk("thaw_fill",  64'(bus_m.fill_level), 64'd2);

    // Reset asserted between clock edges must act immediately
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",    64'(bus_m.evt_valid), 64'd0);
    chk("arst_fill",     64'(bus_m.fill_level), 64'd0);
    chk("arst_overflow", 64'(bus_m.overflow), 64'd0);
    chk("arst_drop",     64'(bus_m.drop_cnt), 64'd0);
    chk("arst_stage",    bus_m.llc_stage, 64'd0);
    chk("arst_time",     bus_m.evt_time, 64'd0);
    step();
    rst = 1'b0;
    bus_m.en = 1'b0;

    // Periodic instance: ticks at times 9,19,29; input merged at 19
    bus_p.en = 1'b1;
    pops = 0; peak = 0;
    for (int n = 0; n < 36; n++) begin
      bus_p.in_new  = (n == 19) ? 3'b001 : 3'b000;
      bus_p.in_data = {64'd0, 64'd0, 64'd42};
      step();
      if (int'(bus_p.fill_level) > peak) peak = int'(bus_p.fill_level);
      if (bus_p.evt_valid) begin
        if (pops < 3) begin
          chk($sformatf("per%0d_time", pops),     bus_p.evt_time, p_time[pops]);
          chk($sformatf("per%0d_periodic", pops), 64'(bus_p.evt_periodic), 64'd1);
          chk($sformatf("per%0d_new", pops),      64'(bus_p.evt_new), 64'(p_new[pops]));
          chk($sformatf("per%0d_lane0", pops),    bus_p.evt_data[63:0], p_d0[pops]);
        end
        pops++;
      end
    end
    chk("per_events",    64'(pops), 64'd3);
    chk("per_peak_fill", 64'(peak), 64'd1);
    chk("per_overflow",  64'(bus_p.overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hlc_event_queue.md
Name: hlc_event_queue

Overview:
- Parametrised input front-end for generated RTLola monitors.
- Samples NUM_IN input streams with per-stream new flags on every enabled cycle. Merges them with an optional periodic (time-triggered) tick into one timestamped event and buffers the event in a DEPTH-entry FIFO.
- Releases one event per low-level-controller (LLC) round of STAGES cycles. The LLC always receives new data at stage 0, so input producers need not align to the stage counter.

Parameters:
- NUM_IN, 3, number of input streams
- DATA_W, 64, width of each input value (signed, two's complement)
- DEPTH, 8, FIFO entries (power of two, >=2)
- STAGES, 5, LLC stages per monitor round (>=2)
- STAGE_W, 64, width of llc_stage output
- TIME_W, 64, width of timestamp counter
- PERIOD, 500, enabled cycles between periodic ticks; 0 disables ticks

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable; 0 freezes all state
- in_data  in  NUM_IN*DATA_W  packed values, stream i at bits [i*DATA_W +: DATA_W]
- in_new  in  NUM_IN  new-value flag per stream
- evt_valid  out  1  event presented to LLC this round
- evt_data  out  NUM_IN*DATA_W  event values (non-new lanes are 0)
- evt_new  out  NUM_IN  which lanes carry new values
- evt_periodic  out  1  event contains a periodic tick
- evt_time  out  TIME_W  timestamp of event capture
- llc_stage  out  STAGE_W  current LLC stage, 0..STAGES-1
- fill_level  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped
- drop_cnt  out  16  dropped events, saturating at 16'hFFFF

Behaviour:
- Reset (async, while rst=1): all outputs 0, FIFO empty, time counter 0, period counter 0, llc_stage 0.
- en=0: no state changes at all (time, period, stage, FIFO, outputs held). Any in_new asserted is ignored.
- Time counter: +1 each enabled cycle, wraps modulo 2^TIME_W. An event captured at edge t carries the pre-increment value.
- Period counter: counts 0..PERIOD-1 on enabled cycles. tick=1 when the count is PERIOD-1, then the count wraps to 0. PERIOD=0: tick never asserts.
- Capture: push when en and (|in_new or tick). Entry = {time, in_new, in_data masked by in_new, tick}. A simultaneous input and tick form ONE entry.
- Stage counter: 0..STAGES-1, wraps, advances each enabled cycle.
- Pop: at an enabled edge with llc_stage==STAGES-1.
  - FIFO non-empty: pop the head into the evt_* registers and set evt_valid=1.
  - FIFO empty: evt_valid=0.
  - evt_valid is therefore high exactly during llc_stage==0 cycles that follow a pop.
  - evt_valid clears at the next edge. evt_data/new/time/periodic hold until the next pop.
- Latency: minimum 2 cycles from capture edge to evt_valid (capture at the edge where llc_stage goes STAGES-2→STAGES-1, pop at the next edge). Maximum without backlog is STAGES+1.
- FIFO has no same-cycle bypass. An entry written at edge t is poppable at edge t+1 or later.
- Simultaneous push and pop: both occur and fill_level is unchanged. This holds even when full (pop frees the slot first), so no drop occurs.
- Full without pop: the push is discarded, overflow←1 (sticky until reset), drop_cnt+1 (saturating). FIFO contents are unchanged.
- fill_level reflects the registered occupancy after the edge.
- Reset mid-operation: FIFO contents are discarded immediately. evt_valid drops asynchronously.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then en=1, PERIOD=0, no inputs for 20 cycles → evt_valid never 1; llc_stage cycles 0,1,2,3,4,0…; all other outputs 0.
- Single event: at the time-5 edge (en high from time 0, llc_stage 0→1) drive in_new=3'b111, in_data={2,1,1} (id,b,a) → at stage 0 of the next round (cycle 10) evt_valid=1, evt_new=3'b111, evt_data lanes {2,1,1}, evt_time=5, evt_periodic=0. Valid for exactly one cycle.
- Partial lanes: in_new=3'b101, in_data lane1=7 → evt_new=3'b101, evt_data lane1=0, lanes 0/2 equal the driven values.
- Periodic merge: PERIOD=10, drive in_new=3'b001 in the cycle where period count=9 → one event with evt_periodic=1 and evt_new=3'b001. With PERIOD=10 and no inputs, evt_periodic events arrive every 10 cycles, evt_time = 9, 19, 29….
- Overflow: push 12 consecutive events (in_new=1 each cycle, PERIOD=0) with DEPTH=8 → fill_level peaks at 8, overflow=1, drop_cnt=2 (two pops occur in the window). Popped evt_time values are strictly increasing with no reorder.
- en freeze / async reset: with 3 entries queued, drop en for 7 cycles → llc_stage, fill_level and evt_time unchanged. Then pulse rst mid-cycle → fill_level=0, evt_valid=0 immediately, overflow=0.
